mips_exec_mem_unit: RTL and testbench
=====================================

// Module: mips_exec_mem_unit
// PURPOSE
//  Execute/memory slice of the single-cycle MIPS datapath: main+ALU control decoder, ALU
//  with src-B mux, word-addressed data memory and write-back result mux. Sits between
//  register file/sign extender (operands) and register-file write port / PC select logic.
//  All paths combinational except the memory write and the async memory clear.
// PARAMETERS
//  AW  6   data-memory word-address width (2**AW words)
//  DW  32  data width; operands, ALU and memory words
// PORTS
//  clk          in   1   clock; memory writes on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  opcode       in   6   instr[31:26]
//  funct        in   6   instr[5:0]
//  rd1          in   DW  register read data 1 (ALU src A)
//  rd2          in   DW  register read data 2 (src B when alu_src=0; memory write data)
//  sign_imm     in   DW  sign-extended immediate (src B when alu_src=1)
//  reg_write    out  1   register-file write enable
//  reg_dst      out  1   1: dest = rd field, 0: rt field
//  alu_src      out  1   src B select
//  mem_write    out  1   data-memory write enable
//  mem_to_reg   out  1   1: result = read_data, 0: result = alu_result
//  branch       out  1   beq decoded
//  pc_src       out  1   branch & zero
//  jump         out  1   j decoded
//  alu_control  out  3   ALU operation code
//  alu_result   out  DW  ALU output; also memory byte address
//  zero         out  1   alu_result == 0
//  read_data    out  DW  memory word at alu_result[AW+1:2]
//  result       out  DW  write-back value
// BEHAVIOUR
//  Main decode (reg_write,reg_dst,alu_src,branch,mem_write,mem_to_reg,jump,aluop[1:0]):
//   000000 R-type 1,1,0,0,0,0,0,10 | 100011 lw 1,0,1,0,0,1,0,00 | 101011 sw 0,0,1,0,1,0,0,00
//   000100 beq 0,0,0,1,0,0,0,01 | 001000 addi 1,0,1,0,0,0,0,00 | 000010 j 0,0,0,0,0,0,1,00
//   any other opcode: all controls 0, aluop 00 (no register or memory write).
//  ALU decode: aluop 00->010; 01->110; 10 by funct: 100000->010, 100010->110, 100100->000,
//   100101->001, 101010->111, other funct->010. aluop 11 unreachable, treat as 010.
//  ALU (B = alu_src ? sign_imm : rd2): 000 A&B; 001 A|B; 010 A+B; 110 A-B;
//   111 signed A<B ? 1 : 0; 100 A&~B; 101 A|~B; 011 -> 0. Add/sub modulo 2**DW, no overflow flag.
//  zero = (alu_result == 0); pc_src = branch & zero.
//  Memory: 2**AW words; index = alu_result[AW+1:2]; bits [1:0] and above AW+1 ignored (wrap).
//   Read combinational (asynchronous). Write on posedge clk when mem_write=1 and rst_n=1;
//   same-cycle read returns old word until the edge.
//  Reset: rst_n low clears every memory word to 0 immediately and blocks writes; read_data=0
//   throughout reset. Control/ALU outputs stay purely combinational (no reset dependency).
//  result = mem_to_reg ? read_data : alu_result.
// TESTING
//  R add: op 0, funct 100000, rd1=5, rd2=7 -> alu_control 010, alu_result 12, reg_write=1,
//   reg_dst=1, result 12, zero 0.
//  sw then lw: sw rd1=8, sign_imm=4, rd2=0xDEADBEEF, edge -> lw same addr gives
//   read_data/result 0xDEADBEEF, mem_to_reg=1; addr 12+256 aliases word 3.
//  beq: rd1=rd2=9 -> alu_control 110, zero 1, pc_src 1; rd2=10 -> pc_src 0.
//  slt signed: rd1=0xFFFFFFFF, rd2=1, funct 101010 -> result 1; swapped -> 0.
//  Reset: write word 2, pulse rst_n low mid-cycle -> read_data 0 at once; write with rst_n low
//   has no effect.
//  Unknown opcode 111111 with clk running -> all controls 0, memory unchanged; j -> jump=1 only.

Source files
------------

// File: rtl/mips_exec_mem_unit.sv
// Execute/memory slice of a single-cycle MIPS datapath: control decode, ALU,
// word-addressed data memory with asynchronous clear, and write-back select.
module mips_exec_mem_unit #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [5:0]    opcode,
    input  logic [5:0]    funct,
    input  logic [DW-1:0] rd1,
    input  logic [DW-1:0] rd2,
    input  logic [DW-1:0] sign_imm,
    output logic          reg_write,
    output logic          reg_dst,
    output logic          alu_src,
    output logic          mem_write,
    output logic          mem_to_reg,
    output logic          branch,
    output logic          pc_src,
    output logic          jump,
    output logic [2:0]    alu_control,
    output logic [DW-1:0] alu_result,
    output logic          zero,
    output logic [DW-1:0] read_data,
    output logic [DW-1:0] result
);

    localparam int DEPTH = 2 ** AW;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_NONE = 3'b011;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    logic [1:0]    w_aluop;
    logic [DW-1:0] w_src_b;
    logic [AW-1:0] w_index;
    logic [DW-1:0] r_mem [0:DEPTH-1];

    // Main decoder; unlisted opcodes leave every control low so nothing is written.
    always_comb begin
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        branch     = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        jump       = 1'b0;
        w_aluop    = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_aluop   = 2'b10;
            end
            OP_LW: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                branch  = 1'b1;
                w_aluop = 2'b01;
            end
            OP_ADDI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            OP_J: begin
                jump = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (w_aluop)
            2'b01: alu_control = ALU_SUB;
            2'b10: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    assign w_src_b = alu_src ? sign_imm : rd2;

    always_comb begin
        alu_result = '0;
        case (alu_control)
            ALU_AND:  alu_result = rd1 & w_src_b;
            ALU_OR:   alu_result = rd1 | w_src_b;
            ALU_ADD:  alu_result = rd1 + w_src_b;
            ALU_SUB:  alu_result = rd1 - w_src_b;
            ALU_SLT:  alu_result = ($signed(rd1) < $signed(w_src_b)) ? DW'(1) : '0;
            ALU_ANDN: alu_result = rd1 & ~w_src_b;
            ALU_ORN:  alu_result = rd1 | ~w_src_b;
            ALU_NONE: alu_result = '0;
            default:  alu_result = '0;
        endcase
    end

    assign zero   = (alu_result == '0);
    assign pc_src = branch & zero;

    // Byte address to word index; low two bits and upper bits are dropped so addresses wrap.
    assign w_index = alu_result[AW+1:2];

    // Register-based store so the whole array can be cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (mem_write) begin
            r_mem[w_index] <= rd2;
        end
    end

    assign read_data = rst_n ? r_mem[w_index] : '0;
    assign result    = mem_to_reg ? read_data : alu_result;

endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// Scoreboard bench for mips_exec_mem_unit: directed instructions push expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mips_exec_mem_unit;

    localparam int AW = 6;
    localparam int DW = 32;

    localparam int SEL_CTRL = 0;
    localparam int SEL_ALUC = 1;
    localparam int SEL_ALUR = 2;
    localparam int SEL_ZERO = 3;
    localparam int SEL_RDAT = 4;
    localparam int SEL_RES  = 5;

    logic          clk;
    logic          rst_n;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] sign_imm;
    logic          reg_write;
    logic          reg_dst;
    logic          alu_src;
    logic          mem_write;
    logic          mem_to_reg;
    logic          branch;
    logic          pc_src;
    logic          jump;
    logic [2:0]    alu_control;
    logic [DW-1:0] alu_result;
    logic          zero;
    logic [DW-1:0] read_data;
    logic [DW-1:0] result;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests;
    int   n_fail;

    mips_exec_mem_unit #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .rd1        (rd1),
        .rd2        (rd2),
        .sign_imm   (sign_imm),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .branch     (branch),
        .pc_src     (pc_src),
        .jump       (jump),
        .alu_control(alu_control),
        .alu_result (alu_result),
        .zero       (zero),
        .read_data  (read_data),
        .result     (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SEL_CTRL: return {24'd0, reg_write, reg_dst, alu_src, branch,
                              mem_write, mem_to_reg, jump, pc_src};
            SEL_ALUC: return {29'd0, alu_control};
            SEL_ALUR: return alu_result;
            SEL_ZERO: return {31'd0, zero};
            SEL_RDAT: return read_data;
            SEL_RES:  return result;
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: the DUT output is combinational, so every pending expectation is due at this negedge.
    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [31:0] a;
                e = sb_q.pop_front();
                a = actual(e.sel);
                n_tests++;
                if (a !== e.exp) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.exp);
                end else begin
                    $display("[TB] ok   %s: 0x%08h", e.name, a);
                end
            end
        end
    end

    task automatic push(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        @(posedge clk);
        #1;
        opcode   = op;
        funct    = fn;
        rd1      = a;
        rd2      = b;
        sign_imm = imm;
    endtask

    // ctrl bundle: {reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg, jump, pc_src}
    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        opcode   = 6'b100011;
        funct    = 6'd0;
        rd1      = 32'd12;
        rd2      = 32'd0;
        sign_imm = 32'd0;
        push("reset_read_data", SEL_RDAT, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
        push("radd_ctrl", SEL_CTRL, 32'h0000_00C0);
        push("radd_aluc", SEL_ALUC, 32'd2);
        push("radd_alur", SEL_ALUR, 32'd12);
        push("radd_res",  SEL_RES,  32'd12);
        push("radd_zero", SEL_ZERO, 32'd0);

        drive(6'b101011, 6'd0, 32'd8, 32'hDEAD_BEEF, 32'd4);
        push("sw_ctrl",     SEL_CTRL, 32'h0000_0028);
        push("sw_alur",     SEL_ALUR, 32'd12);
        push("sw_old_word", SEL_RDAT, 32'd0);

        drive(6'b100011, 6'd0, 32'd8, 32'd0, 32'd4);
        push("lw_ctrl", SEL_CTRL, 32'h0000_00A4);
        push("lw_rdat", SEL_RDAT, 32'hDEAD_BEEF);
        push("lw_res",  SEL_RES,  32'hDEAD_BEEF);

        drive(6'b100011, 6'd0, 32'd268, 32'd0, 32'd0);
        push("lw_alias_rdat", SEL_RDAT, 32'hDEAD_BEEF);

        drive(6'b000100, 6'd0, 32'd9, 32'd9, 32'd0);
        push("beq_eq_ctrl", SEL_CTRL, 32'h0000_0011);
        push("beq_eq_aluc", SEL_ALUC, 32'd6);
        push("beq_eq_zero", SEL_ZERO, 32'd1);

        drive(6'b000100, 6'd0, 32'd9, 32'd10, 32'd0);
        push("beq_ne_ctrl", SEL_CTRL, 32'h0000_0010);
        push("beq_ne_alur", SEL_ALUR, 32'hFFFF_FFFF);

        drive(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0);
        push("slt_aluc", SEL_ALUC, 32'd7);
        push("slt_res",  SEL_RES,  32'd1);

        drive(6'b000000, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'd0);
        push("slt_swap_res", SEL_RES, 32'd0);

        drive(6'b000000, 6'b100010, 32'd3, 32'd5, 32'd0);
        push("sub_res", SEL_RES, 32'hFFFF_FFFE);

        drive(6'b000000, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00, 32'd0);
        push("and_aluc", SEL_ALUC, 32'd0);
        push("and_res",  SEL_RES,  32'h0000_F000);

        drive(6'b000000, 6'b100101, 32'h0000_F0F0, 32'h0000_FF00, 32'd0);
        push("or_aluc", SEL_ALUC, 32'd1);
        push("or_res",  SEL_RES,  32'h0000_FFF0);

        drive(6'b000000, 6'b000111, 32'd20, 32'd22, 32'd0);
        push("badfn_aluc", SEL_ALUC, 32'd2);
        push("badfn_res",  SEL_RES,  32'd42);

        drive(6'b001000, 6'd0, 32'd100, 32'd55, 32'hFFFF_FFFF);
        push("addi_ctrl", SEL_CTRL, 32'h0000_00A0);
        push("addi_res",  SEL_RES,  32'd99);

        drive(6'b111111, 6'd0, 32'd12, 32'h1234_5678, 32'd0);
        push("badop_ctrl", SEL_CTRL, 32'h0000_0000);
        push("badop_aluc", SEL_ALUC, 32'd2);
        drive(6'b111111, 6'd0, 32'd0, 32'd12, 32'd0);
        push("badop2_ctrl", SEL_CTRL, 32'h0000_0000);

        drive(6'b100011, 6'd0, 32'd12, 32'd0, 32'd0);
        push("mem_kept_rdat", SEL_RDAT, 32'hDEAD_BEEF);

        drive(6'b000010, 6'd0, 32'd0, 32'd0, 32'd0);
        push("j_ctrl", SEL_CTRL, 32'h0000_0002);

        drive(6'b101011, 6'd0, 32'd8, 32'hCAFE_F00D, 32'd0);
        drive(6'b100011, 6'd0, 32'd8, 32'd0, 32'd0);
        push("w2_rdat", SEL_RDAT, 32'hCAFE_F00D);

        // Mid-cycle reset pulse while reading the written word
        drive(6'b100011, 6'd0, 32'd8, 32'd0, 32'd0);
        #1 rst_n = 1'b0;
        push("rst_mid_rdat", SEL_RDAT, 32'd0);
        push("rst_mid_res",  SEL_RES,  32'd0);

        drive(6'b101011, 6'd0, 32'd8, 32'h1111_1111, 32'd0);
        push("rst_sw_ctrl", SEL_CTRL, 32'h0000_0028);
        drive(6'b100011, 6'd0, 32'd8, 32'd0, 32'd0);
        push("rst_lw_rdat", SEL_RDAT, 32'd0);
        #1 rst_n = 1'b1;
        push("post_rst_w2", SEL_RDAT, 32'd0);

        drive(6'b100011, 6'd0, 32'd12, 32'd0, 32'd0);
        push("post_rst_w3", SEL_RDAT, 32'd0);

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
